// File: rtl/acc_frame_20_bit.sv
// Frame accumulator that sits behind the 20-bit ripple adder.
// It sums frame_len unsigned 20-bit samples (modulo 2^20), keeps a sticky
// carry-out flag for the frame, and offers the total on a valid/ready port.
//
// Handshake rules, both ports:
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A producer holds valid and its data stable until the transfer happens.
//   ready never depends on valid in this block; in_ready and out_valid are
//   decoded from the registered state only.

// 20-bit ripple-carry adder used as the datapath adder.
module add_20_bit (
  input  logic [19:0] a,
  input  logic [19:0] b,
  input  logic        cin,
  output logic [19:0] sum,
  output logic        cout
);

  logic [20:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling from bit 0 upward.
  genvar i;
  generate
    for (i = 0; i < 20; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = c[20];

endmodule

module acc_frame_20_bit #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [19:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [19:0]      out_sum,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [19:0]        acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic               accept;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W-1:0]   cnt_inc;
  logic [19:0]        add_sum;
  logic               add_cout;

  // The adder's carry out is exactly the "new sum < old acc" lost-carry event.
  add_20_bit u_add (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

  assign accept  = in_valid && in_ready;
  // A zero length field means a single-sample frame.
  assign len_eff = (frame_len == '0) ? LEN_W'(1) : frame_len;
  assign cnt_inc = cnt_q + LEN_W'(1);

  // Next-state and datapath update; everything holds unless an event occurs.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          ovf_d   = 1'b0;
          cnt_d   = LEN_W'(1);
          len_d   = len_eff;
          state_d = (len_eff == LEN_W'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_cout;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: doc/acc_frame_20_bit.md
Name: acc_frame_20_bit

Overview:
- Sequential accumulation stage that sits directly downstream of the 20-bit ripple adder `add_20_bit`.
- Registers a running 20-bit sum over a frame of N input samples, using one `add_20_bit` instance as its datapath adder.
- Presents the frame total on a valid/ready output port, with a sticky unsigned-overflow flag.
- Feeds the next parallel-reduction stage.

Parameters:
- LEN_W, 8, width of frame_len; maximum frame length is 2^LEN_W-1 samples.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- frame_len  input  LEN_W  samples per frame; 0 is treated as 1; sampled only when a frame's first sample is accepted.
- in_data  input  20  unsigned operand.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample this cycle.
- out_sum  output  20  frame total, modulo 2^20.
- out_ovf  output  1  at least one carry out of bit 19 occurred during the frame.
- out_valid  output  1  out_sum/out_ovf are valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, acc=0, cnt=0, len_q=0, ovf=0.
  - Outputs: out_sum=0, out_ovf=0, out_valid=0, in_ready=1 on the following cycle.
  - Reset mid-frame or in HOLD discards the partial or pending result; nothing is emitted afterwards.
- Accept event: in_valid && in_ready at a clk edge. Output handoff: out_valid && out_ready at a clk edge.
- States: IDLE, ACCUM, HOLD.
  - in_ready=1 in IDLE and ACCUM; in_ready=0 in HOLD (registered decode of state).
  - out_valid=1 only in HOLD.
- IDLE:
  - On accept: acc<=in_data, ovf<=0, cnt<=1, len_q<=max(frame_len,1).
  - If max(frame_len,1)==1, go to HOLD; otherwise go to ACCUM.
  - No accept: hold all state.
- ACCUM:
  - On accept: acc<=add_20_bit(acc,in_data); ovf<=ovf | (new sum < acc, unsigned compare, i.e. lost carry); cnt<=cnt+1.
  - If cnt+1==len_q, go to HOLD.
  - No accept (in_valid=0 bubbles): hold all state indefinitely.
- HOLD:
  - out_sum=acc and out_ovf=ovf, both driven from registers and stable while out_valid=1 and out_ready=0.
  - On handoff: go to IDLE; out_valid drops the next cycle. acc/ovf are retained but don't-care until the next frame.
- Latency: out_valid rises exactly 1 cycle after the edge that accepts a frame's last sample.
- Throughput: 1 idle cycle per frame, because in_ready=0 in HOLD. Back-to-back frames cost N+1 cycles minimum with out_ready tied high.
- frame_len changes outside the first-sample accept are ignored for the current frame.
- Arithmetic:
  - Unsigned, modulo 2^20; the wrap result is the plain 20-bit sum.
  - The ovf flag is sticky for the frame and cleared at the next frame's first sample.
- cnt is LEN_W bits wide; it never exceeds len_q, so it never wraps.
- Driving in_valid while in_ready=0 has no effect. The upstream stage must hold its data until it is accepted.

Test Plan:
1. Reset then basic frame: rst_n low 2 cycles; frame_len=4; inputs 1,2,3,4 on consecutive cycles, out_ready=1 → out_valid high the cycle after the 4th accept, out_sum=10, out_ovf=0; in_ready=0 during that cycle.
2. Overflow/wrap: frame_len=2; inputs 20'hFFFFF then 20'h00002 → out_sum=20'h00001, out_ovf=1. Next frame, frame_len=1, input 5 → out_sum=5, out_ovf=0 (flag cleared).
3. Backpressure and bubbles: frame_len=3; inputs 7, gap of 3 idle cycles, 8, 9; out_ready=0 for 5 cycles → out_sum=24, held stable with out_valid=1; in_ready=0 throughout; inputs offered during HOLD are not accepted. Raise out_ready → IDLE next cycle.
4. frame_len=0 and mid-frame change: frame_len=0, input 33 → single-sample frame, out_sum=33. Then frame_len=2, first sample 10, change frame_len to 5, second sample 20 → frame ends after 2 samples, out_sum=30.
5. Reset mid-operation: frame_len=4; accept 3 samples; assert rst_n=0 for 1 cycle → out_valid=0, out_sum=0, in_ready=1. A new frame_len=2 frame of 4 and 6 → out_sum=10 (no stale contribution).
6. Maximum length: LEN_W=8, frame_len=255, all inputs 20'h01000 → out_sum=20'hFF000, out_ovf=0, out_valid exactly 1 cycle after the 255th accept.
